// File: rtl/seg7_to_binary.sv
// seg7_to_binary: turns captured hundreds/tens/ones 7-segment codes back into an 8-bit value via reverse double-dabble.
// Optional SEG7DEC_DP_CHECK_EN: a lit DP on any digit is treated as an invalid pattern.
module seg7_to_binary (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] l1,
   input  logic [7:0] l2,
   input  logic [7:0] l3,
   output logic       busy,
   output logic       done,
   output logic [7:0] num,
   output logic       err
);
   typedef enum logic [1:0] {IDLE, DECODE, SHIFT, FINISH} state_t;
   state_t state, state_n;
   logic [7:0] c1, c2, c3;
   logic [17:0] sr, sh, sr_n;
   logic [2:0] cnt;
   logic [4:0] d1, d2, d3;
   logic dp_bad, ok, over;
   // returns {valid, digit}; DP is masked before matching
   function automatic logic [4:0] seg(input logic [7:0] c);
      case (c & 8'hFE)
         8'hFC: seg = 5'h10;
         8'h60: seg = 5'h11;
         8'hDA: seg = 5'h12;
         8'hF2: seg = 5'h13;
         8'h66: seg = 5'h14;
         8'hB6: seg = 5'h15;
         8'hBE: seg = 5'h16;
         8'hE0: seg = 5'h17;
         8'hFE: seg = 5'h18;
         8'hE6: seg = 5'h19;
         default: seg = 5'h00;
      endcase
   endfunction
   assign d1 = seg(c1);
   assign d2 = seg(c2);
   assign d3 = seg(c3);
`ifdef SEG7DEC_DP_CHECK_EN
   assign dp_bad = c1[0] | c2[0] | c3[0];
`else
   assign dp_bad = 1'b0;
`endif
   assign ok = d1[4] & d2[4] & d3[4] & (d1[3:0] <= 4'd2) & ~dp_bad;
   assign sh = sr >> 1;
   assign sr_n = {sh[17:16],
                  sh[15:12] >= 4'd8 ? sh[15:12] - 4'd3 : sh[15:12],
                  sh[11:8] >= 4'd8 ? sh[11:8] - 4'd3 : sh[11:8],
                  sh[7:0]};
   // any BCD left after the last shift means the value exceeded 255
   assign over = |sr_n[17:8];
   assign busy = state != IDLE;
   assign done = state == FINISH;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:   state_n = start ? DECODE : IDLE;
         DECODE: state_n = ok ? SHIFT : FINISH;
         SHIFT:  state_n = cnt == 3'd7 ? FINISH : SHIFT;
         FINISH: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         c1 <= '0;
         c2 <= '0;
         c3 <= '0;
         sr <= '0;
         cnt <= '0;
         num <= '0;
         err <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  c1 <= l1;
                  c2 <= l2;
                  c3 <= l3;
               end
            DECODE:
               if (ok) begin
                  sr <= {d1[1:0], d2[3:0], d3[3:0], 8'd0};
                  cnt <= '0;
               end else begin
                  num <= '0;
                  err <= 1'b1;
               end
            SHIFT: begin
               sr <= sr_n;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  num <= over ? 8'd0 : sr_n[7:0];
                  err <= over;
               end
            end
            FINISH: ;
         endcase
      end
endmodule
